tiro_fileira: RTL and testbench

Enemy-fire engine for one row of enemies. It takes the row's packed enemy positions and alive mask, and periodically picks a live enemy pseudo-randomly. It then launches one downward projectile from that enemy, moves it every game tick, and reports a hit on the player ship. It sits beside the enemy-row block and drives the ship-side damage logic.

---
 rtl/tiro_fileira.sv | 163 ++++++++++++++++
 tb/tb_tiro_fileira.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiro_fileira.sv
// tiro_fileira: enemy-fire engine for one row of five enemies.
// Every INTERVALO ticks a live enemy is picked through an 8-bit LFSR, a single
// projectile is launched from it and descends VEL_Y pixels per tick until it
// hits the player ship (one-tick acertou_nave pulse) or reaches the floor.
module tiro_fileira #(
    parameter int         INTERVALO = 60,
    parameter int         VEL_Y     = 4,
    parameter int         Y_LIMITE  = 480,
    parameter int         OFFSET_X  = 16,
    parameter int         OFFSET_Y  = 16,
    parameter int         NAVE_LARG = 33,
    parameter int         NAVE_ALT  = 16,
    parameter logic [7:0] SEMENTE   = 8'hA5
) (
    input  logic        CLOCK_MV,
    input  logic        reset,
    input  logic        reiniciarJogo,
    input  logic        pausa,
    input  logic [49:0] inimigo_x,
    input  logic [49:0] inimigo_y,
    input  logic [4:0]  vivo,
    input  logic [9:0]  nave_x,
    input  logic [9:0]  nave_y,
    output logic [9:0]  bola_x,
    output logic [9:0]  bola_y,
    output logic        bola_ativa,
    output logic        acertou_nave,
    output logic [7:0]  tiros
);

    localparam int CW = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ESCOLHE = 2'd1,
        VOO     = 2'd2
    } estado_t;

    estado_t         estado_r;
    logic [CW-1:0]   contador_r;
    logic [7:0]      lfsr_r;

    logic [2:0]      atirador_s;
    logic [9:0]      orig_x_s;
    logic [9:0]      orig_y_s;
    logic            acerto_s;
    logic            chao_s;

    // Next LFSR value: shift left, feedback taps 7,5,4,3 into bit 0.
    function automatic logic [7:0] lfsr_prox(input logic [7:0] v);
        lfsr_prox = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // First alive enemy scanning circularly from the candidate drawn from the LFSR.
    function automatic logic [2:0] escolhe_atirador(input logic [2:0] sorteio,
                                                    input logic [4:0] mascara);
        logic [2:0] cand;
        logic [2:0] idx;
        logic       achou;
        cand  = (sorteio >= 3'd5) ? (sorteio - 3'd5) : sorteio;
        escolhe_atirador = cand;
        achou = 1'b0;
        idx   = cand;
        for (int i = 0; i < 5; i++) begin
            if (!achou && mascara[idx]) begin
                escolhe_atirador = idx;
                achou = 1'b1;
            end else begin
                achou = achou;
            end
            idx = (idx == 3'd4) ? 3'd0 : (idx + 3'd1);
        end
    endfunction

    // Extracts the 10-bit coordinate of enemy k from a packed row vector.
    function automatic logic [9:0] seleciona(input logic [49:0] pacote,
                                             input logic [2:0]  k);
        case (k)
            3'd0:    seleciona = pacote[9:0];
            3'd1:    seleciona = pacote[19:10];
            3'd2:    seleciona = pacote[29:20];
            3'd3:    seleciona = pacote[39:30];
            3'd4:    seleciona = pacote[49:40];
            default: seleciona = pacote[9:0];
        endcase
    endfunction

    // Chooses this tick's shooter and fetches its origin coordinates.
    always_comb begin
        atirador_s = escolhe_atirador(lfsr_r[2:0], vivo);
        orig_x_s   = seleciona(inimigo_x, atirador_s);
        orig_y_s   = seleciona(inimigo_y, atirador_s);
    end

    // Hit box and floor tests, widened to 11 bits so nothing wraps.
    always_comb begin
        acerto_s = ({1'b0, nave_x} <= {1'b0, bola_x}) &&
                   ({1'b0, bola_x} <  ({1'b0, nave_x} + 11'(NAVE_LARG))) &&
                   ({1'b0, nave_y} <= {1'b0, bola_y}) &&
                   ({1'b0, bola_y} <  ({1'b0, nave_y} + 11'(NAVE_ALT)));
        chao_s   = ({1'b0, bola_y} + 11'(VEL_Y)) >= 11'(Y_LIMITE);
    end

    // Fire FSM: wait interval, pick shooter, fly projectile; hit pulse self-clears.
    always_ff @(posedge CLOCK_MV) begin
        if (reset || reiniciarJogo) begin
            estado_r     <= ESPERA;
            contador_r   <= '0;
            lfsr_r       <= SEMENTE;
            bola_x       <= 10'd0;
            bola_y       <= 10'd0;
            bola_ativa   <= 1'b0;
            acertou_nave <= 1'b0;
            tiros        <= 8'd0;
        end else begin
            acertou_nave <= 1'b0;
            if (!pausa) begin
                lfsr_r <= lfsr_prox(lfsr_r);
                case (estado_r)
                    ESPERA: begin
                        if (contador_r == CW'(INTERVALO - 1)) begin
                            contador_r <= '0;
                            estado_r   <= ESCOLHE;
                        end else begin
                            contador_r <= contador_r + CW'(1);
                        end
                    end
                    ESCOLHE: begin
                        if (vivo == 5'd0) begin
                            estado_r <= ESPERA;
                        end else begin
                            bola_x     <= orig_x_s + 10'(OFFSET_X);
                            bola_y     <= orig_y_s + 10'(OFFSET_Y);
                            bola_ativa <= 1'b1;
                            tiros      <= tiros + 8'd1;
                            estado_r   <= VOO;
                        end
                    end
                    VOO: begin
                        if (acerto_s) begin
                            acertou_nave <= 1'b1;
                            bola_ativa   <= 1'b0;
                            estado_r     <= ESPERA;
                        end else if (chao_s) begin
                            bola_ativa   <= 1'b0;
                            estado_r     <= ESPERA;
                        end else begin
                            bola_y       <= bola_y + 10'(VEL_Y);
                        end
                    end
                    default: begin
                        estado_r   <= ESPERA;
                        contador_r <= '0;
                        bola_ativa <= 1'b0;
                    end
                endcase
            end else begin
                estado_r <= estado_r;
            end
        end
    end

endmodule

// File: tb/tb_tiro_fileira.sv
// Testbench for tiro_fileira: table of single-flight scenarios, hand-written
// timing sequences and a randomized run, all compared against a tick-level
// behavioural model kept in the bench.
module tb_tiro_fileira;

    localparam int INTERVALO = 4;
    localparam int SEED      = 8'hA5;

    logic        CLOCK_MV;
    logic        reset;
    logic        reiniciarJogo;
    logic        pausa;
    logic [49:0] inimigo_x;
    logic [49:0] inimigo_y;
    logic [4:0]  vivo;
    logic [9:0]  nave_x;
    logic [9:0]  nave_y;
    logic [9:0]  bola_x;
    logic [9:0]  bola_y;
    logic        bola_ativa;
    logic        acertou_nave;
    logic [7:0]  tiros;

    logic [9:0]  ex [5];
    logic [9:0]  ey [5];

    int checks = 0;
    int errors = 0;

    // model state
    int m_lfsr, m_wait, m_x, m_y, m_shots;
    bit m_choose, m_fly, m_hit;

    assign inimigo_x = {ex[4], ex[3], ex[2], ex[1], ex[0]};
    assign inimigo_y = {ey[4], ey[3], ey[2], ey[1], ey[0]};

    tiro_fileira #(.INTERVALO(INTERVALO)) dut (
        .CLOCK_MV     (CLOCK_MV),
        .reset        (reset),
        .reiniciarJogo(reiniciarJogo),
        .pausa        (pausa),
        .inimigo_x    (inimigo_x),
        .inimigo_y    (inimigo_y),
        .vivo         (vivo),
        .nave_x       (nave_x),
        .nave_y       (nave_y),
        .bola_x       (bola_x),
        .bola_y       (bola_y),
        .bola_ativa   (bola_ativa),
        .acertou_nave (acertou_nave),
        .tiros        (tiros)
    );

    initial CLOCK_MV = 1'b0;
    always #5 CLOCK_MV = ~CLOCK_MV;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int v);
        int b;
        b = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | b) & 255;
    endfunction

    function automatic int m_shooter(input int lf);
        int c;
        c = lf % 8;
        if (c >= 5) c -= 5;
        for (int i = 0; i < 5; i++)
            if (vivo[(c + i) % 5]) return (c + i) % 5;
        return -1;
    endfunction

    task automatic model_step();
        int lf, k, nx, ny;
        if (reset || reiniciarJogo) begin
            m_lfsr = SEED; m_wait = INTERVALO; m_choose = 0; m_fly = 0;
            m_x = 0; m_y = 0; m_hit = 0; m_shots = 0;
        end else begin
            m_hit = 0;
            if (!pausa) begin
                lf = m_lfsr;
                m_lfsr = lfsr_next(m_lfsr);
                nx = int'(nave_x);
                ny = int'(nave_y);
                if (m_fly) begin
                    if (m_x >= nx && m_x < nx + 33 && m_y >= ny && m_y < ny + 16) begin
                        m_hit = 1; m_fly = 0; m_wait = INTERVALO;
                    end else if (m_y + 4 >= 480) begin
                        m_fly = 0; m_wait = INTERVALO;
                    end else begin
                        m_y += 4;
                    end
                end else if (m_choose) begin
                    m_choose = 0;
                    k = m_shooter(lf);
                    if (k < 0) begin
                        m_wait = INTERVALO;
                    end else begin
                        m_x = (int'(ex[k]) + 16) % 1024;
                        m_y = (int'(ey[k]) + 16) % 1024;
                        m_fly = 1;
                        m_shots = (m_shots + 1) % 256;
                    end
                end else begin
                    m_wait--;
                    if (m_wait == 0) m_choose = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_MV);
        model_step();
        #1;
        chk("m_bola_x", int'(bola_x), m_x);
        chk("m_bola_y", int'(bola_y), m_y);
        chk("m_bola_ativa", int'(bola_ativa), int'(m_fly));
        chk("m_acertou", int'(acertou_nave), int'(m_hit));
        chk("m_tiros", int'(tiros), m_shots);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_row(input int x, input int y);
        for (int k = 0; k < 5; k++) begin
            ex[k] = 10'(x);
            ey[k] = 10'(y);
        end
    endtask

    typedef struct {
        logic [4:0] vivo;
        int ex, ey, nx, ny;
        int exp_x, exp_y, exp_hit;
    } row_t;

    row_t tab [8];

    initial begin
        int n, hits, yh;
        bit rose;
        tab[0] = '{5'b00100, 300,   50, 310, 200, 316, 202, 1};
        tab[1] = '{5'b00100, 300,   50,   0,   0, 316, 478, 0};
        tab[2] = '{5'b00001, 100,   50, 100, 100, 116, 102, 1};
        tab[3] = '{5'b10000, 500,   50, 484, 470, 516, 470, 1};
        tab[4] = '{5'b00100, 300,   50, 283, 200, 316, 478, 0};
        tab[5] = '{5'b00100, 300,   50, 300, 478, 316, 478, 1};
        tab[6] = '{5'b01000, 1015, 1020,  0,   0,   7,  12, 1};
        tab[7] = '{5'b11111, 300,   50, 310, 187, 316, 190, 1};

        reset = 1'b1; reiniciarJogo = 1'b0; pausa = 1'b0;
        vivo = 5'b11111; nave_x = 10'd0; nave_y = 10'd0;
        for (int k = 0; k < 5; k++) begin
            ex[k] = 10'(100 * (k + 1));
            ey[k] = 10'd50;
        end
        tick();
        tick();
        chk("rst_ativa", int'(bola_ativa), 0);
        chk("rst_tiros", int'(tiros), 0);
        chk("rst_bola_y", int'(bola_y), 0);

        // first shot after release: rises on edge 5 from enemy 4
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        chk("pre_launch_ativa", int'(bola_ativa), 0);
        tick();
        chk("launch_ativa", int'(bola_ativa), 1);
        chk("launch_y", int'(bola_y), 66);
        chk("launch_x", int'(bola_x), 516);
        chk("launch_tiros", int'(tiros), 1);

        // no alive enemies: never fires
        vivo = 5'b00000;
        do_reset();
        rose = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bola_ativa) rose = 1;
        end
        chk("dead_row_rose", int'(rose), 0);
        chk("dead_row_tiros", int'(tiros), 0);

        // table of single-flight scenarios
        for (int r = 0; r < 8; r++) begin
            set_row(tab[r].ex, tab[r].ey);
            vivo = tab[r].vivo;
            nave_x = 10'(tab[r].nx);
            nave_y = 10'(tab[r].ny);
            do_reset();
            n = 0;
            while (!bola_ativa && n < 50) begin tick(); n++; end
            chk("row_latency", n, INTERVALO + 1);
            chk("row_x", int'(bola_x), tab[r].exp_x);
            n = 0; hits = 0;
            while (bola_ativa && n < 300) begin
                tick(); n++;
                if (acertou_nave) hits++;
            end
            chk("row_retired", int'(bola_ativa), 0);
            chk("row_final_y", int'(bola_y), tab[r].exp_y);
            chk("row_hits", hits, tab[r].exp_hit);
            chk("row_tiros", int'(tiros), 1);
            tick();
            chk("row_pulse_clear", int'(acertou_nave), 0);
        end

        // twenty shots from the single live enemy
        set_row(300, 50);
        vivo = 5'b00100; nave_x = 10'd0; nave_y = 10'd0;
        do_reset();
        n = 0;
        while (tiros != 8'd20 && n < 3000) begin
            rose = bola_ativa;
            tick(); n++;
            if (!rose && bola_ativa) begin
                chk("shot_x", int'(bola_x), 316);
                chk("shot_y", int'(bola_y), 66);
            end
        end
        chk("twenty_shots", int'(tiros), 20);

        // hit pulse clears even while paused
        nave_x = 10'd310; nave_y = 10'd200;
        do_reset();
        n = 0;
        while (!acertou_nave && n < 200) begin tick(); n++; end
        chk("hit_seen", int'(acertou_nave), 1);
        pausa = 1'b1;
        tick();
        chk("hit_clear_paused", int'(acertou_nave), 0);
        pausa = 1'b0;

        // pause mid-flight, then reset while overlapping the ship
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        pausa = 1'b1;
        yh = int'(bola_y);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pause_y", int'(bola_y), yh);
            chk("pause_tiros", int'(tiros), 1);
        end
        pausa = 1'b0;
        n = 0;
        while (bola_y != 10'd202 && n < 100) begin tick(); n++; end
        chk("overlap_reached", int'(bola_y), 202);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_x", int'(bola_x), 0);
        chk("midrst_y", int'(bola_y), 0);
        chk("midrst_ativa", int'(bola_ativa), 0);
        chk("midrst_acertou", int'(acertou_nave), 0);
        chk("midrst_tiros", int'(tiros), 0);
        tick();
        chk("midrst_no_pulse", int'(acertou_nave), 0);

        // randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) vivo = 5'($urandom);
            if ($urandom_range(0, 49) == 0)
                for (int k = 0; k < 5; k++) begin
                    ex[k] = 10'($urandom);
                    ey[k] = 10'($urandom_range(0, 300));
                end
            if ($urandom_range(0, 29) == 0) begin
                nave_x = 10'(int'(ex[$urandom_range(0, 4)]) + $urandom_range(0, 40) - 16);
                nave_y = 10'($urandom_range(100, 479));
            end
            pausa = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 499) == 0);
            reiniciarJogo = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; reiniciarJogo = 1'b0; pausa = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
